// File: rtl/mag_min2_tracker_seq_if.sv
// Handshake bundle for the least-reliable-position tracker: symbol input side,
// frame abort, result output side and busy status.
interface mag_min2_tracker_seq_if #(
   parameter int MAG_WIDTH = 3,
   parameter int IDX_WIDTH = 8
);
   logic                 in_clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [MAG_WIDTH-1:0] in_mag;
   logic                 out_valid;
   logic                 out_ready;
   logic [MAG_WIDTH-1:0] out_min1_mag;
   logic [IDX_WIDTH-1:0] out_min1_idx;
   logic [MAG_WIDTH-1:0] out_min2_mag;
   logic [IDX_WIDTH-1:0] out_min2_idx;
   logic                 busy;

   modport slave (
      input  in_clear, in_valid, in_mag, out_ready,
      output in_ready, out_valid, out_min1_mag, out_min1_idx,
             out_min2_mag, out_min2_idx, busy
   );

   modport master (
      output in_clear, in_valid, in_mag, out_ready,
      input  in_ready, out_valid, out_min1_mag, out_min1_idx,
             out_min2_mag, out_min2_idx, busy
   );
endinterface

// File: rtl/mag_min2_tracker_seq.sv
// Sequential finder of the two least reliable symbols of one codeword; the
// result is held on a valid/ready port until the consumer takes it.
module mag_min2_tracker_seq #(
   parameter int CODE_LEN  = 255,
   parameter int IDX_WIDTH = 8,
   parameter int MAG_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   mag_min2_tracker_seq_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // Slots carry one extra MSB so an empty slot (all ones) sorts above any magnitude.
   localparam int                   SW         = MAG_WIDTH + 1;
   localparam logic [SW-1:0]        SLOT_EMPTY = '1;
   localparam logic [IDX_WIDTH-1:0] IDX_EMPTY  = '1;
   localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(CODE_LEN - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE    = IDX_WIDTH'(1);

   state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
   logic [SW-1:0]        min1_mag_q, min1_mag_d;
   logic [SW-1:0]        min2_mag_q, min2_mag_d;
   logic [IDX_WIDTH-1:0] min1_idx_q, min1_idx_d;
   logic [IDX_WIDTH-1:0] min2_idx_q, min2_idx_d;
   logic                 in_ready_s;
   logic                 accept_s;
   logic [SW-1:0]        new_mag_s;

   assign in_ready_s = (state_q != ST_HOLD);
   assign accept_s   = bus.in_valid & in_ready_s & ~bus.in_clear;
   assign new_mag_s  = {1'b0, bus.in_mag};

   // Next-state and slot update: clear wins, then accept or result handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      min1_mag_d = min1_mag_q;
      min1_idx_d = min1_idx_q;
      min2_mag_d = min2_mag_q;
      min2_idx_d = min2_idx_q;
      if (bus.in_clear) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         min1_mag_d = SLOT_EMPTY;
         min1_idx_d = IDX_EMPTY;
         min2_mag_d = SLOT_EMPTY;
         min2_idx_d = IDX_EMPTY;
      end else begin
         case (state_q)
            ST_IDLE, ST_COLLECT: begin
               if (accept_s) begin
                  if (new_mag_s < min1_mag_q) begin
                     min2_mag_d = min1_mag_q;
                     min2_idx_d = min1_idx_q;
                     min1_mag_d = new_mag_s;
                     min1_idx_d = cnt_q;
                  end else if (new_mag_s < min2_mag_q) begin
                     min2_mag_d = new_mag_s;
                     min2_idx_d = cnt_q;
                  end else begin
                     min2_mag_d = min2_mag_q;
                  end
                  cnt_d = cnt_q + IDX_ONE;
                  if (cnt_q == IDX_LAST) begin
                     state_d = ST_HOLD;
                  end else begin
                     state_d = ST_COLLECT;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state_d    = ST_IDLE;
                  cnt_d      = '0;
                  min1_mag_d = SLOT_EMPTY;
                  min1_idx_d = IDX_EMPTY;
                  min2_mag_d = SLOT_EMPTY;
                  min2_idx_d = IDX_EMPTY;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               min1_mag_d = SLOT_EMPTY;
               min1_idx_d = IDX_EMPTY;
               min2_mag_d = SLOT_EMPTY;
               min2_idx_d = IDX_EMPTY;
            end
         endcase
      end
   end

   // State, counter and slot registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         min1_mag_q <= SLOT_EMPTY;
         min1_idx_q <= IDX_EMPTY;
         min2_mag_q <= SLOT_EMPTY;
         min2_idx_q <= IDX_EMPTY;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         min1_mag_q <= min1_mag_d;
         min1_idx_q <= min1_idx_d;
         min2_mag_q <= min2_mag_d;
         min2_idx_q <= min2_idx_d;
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = (state_q == ST_HOLD);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.out_min1_mag = min1_mag_q[MAG_WIDTH-1:0];
   assign bus.out_min1_idx = min1_idx_q;
   assign bus.out_min2_mag = min2_mag_q[MAG_WIDTH-1:0];
   assign bus.out_min2_idx = min2_idx_q;
endmodule

// File: tb/tb_mag_min2_tracker_seq.sv
// Random and directed frames for the two-minimum tracker, checked against a
// reference that sorts each frame's accepted symbols by (magnitude, index).
module tb_mag_min2_tracker_seq;
   localparam int CODE_LEN  = 8;
   localparam int IDX_WIDTH = 4;
   localparam int MAG_WIDTH = 3;
   localparam int MAG_ONES  = (1 << MAG_WIDTH) - 1;
   localparam int IDX_ONES  = (1 << IDX_WIDTH) - 1;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;
   int   acc_q[$];
   int   f_case1[CODE_LEN] = '{5, 3, 6, 1, 7, 2, 4, 6};
   int   f_all7[CODE_LEN]  = '{7, 7, 7, 7, 7, 7, 7, 7};
   int   f_case4[CODE_LEN] = '{4, 4, 3, 4, 4, 4, 4, 2};
   int   f_rand[CODE_LEN];
   int   abort_at;

   mag_min2_tracker_seq_if #(.MAG_WIDTH(MAG_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

   mag_min2_tracker_seq #(
      .CODE_LEN (CODE_LEN),
      .IDX_WIDTH(IDX_WIDTH),
      .MAG_WIDTH(MAG_WIDTH)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: first and second entries of the frame in (mag, idx) order.
   task automatic ref_result(output int m1, output int i1, output int m2, output int i2);
      m1 = 1 << MAG_WIDTH; i1 = -1; m2 = 1 << MAG_WIDTH; i2 = -1;
      foreach (acc_q[i]) if (acc_q[i] < m1) begin m1 = acc_q[i]; i1 = i; end
      foreach (acc_q[i]) if (i != i1 && acc_q[i] < m2) begin m2 = acc_q[i]; i2 = i; end
   endtask

   task automatic check_empty(input string tag);
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      check_eq({tag, "_busy"}, 32'(bus.busy), 0);
      check_eq({tag, "_min1_mag"}, 32'(bus.out_min1_mag), MAG_ONES);
      check_eq({tag, "_min1_idx"}, 32'(bus.out_min1_idx), IDX_ONES);
      check_eq({tag, "_min2_mag"}, 32'(bus.out_min2_mag), MAG_ONES);
      check_eq({tag, "_min2_idx"}, 32'(bus.out_min2_idx), IDX_ONES);
   endtask

   task automatic send_beat(input int mag, input int bubbles);
      for (int b = 0; b < bubbles; b++) begin
         bus.in_valid = 1'b0;
         bus.in_mag   = MAG_WIDTH'($urandom_range(0, MAG_ONES));
         @(negedge clk);
      end
      check_eq("in_ready_collect", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_mag   = MAG_WIDTH'(mag);
      @(negedge clk);
      bus.in_valid = 1'b0;
      acc_q.push_back(mag);
   endtask

   task automatic send_frame(input int mags[CODE_LEN], input int max_bubble);
      for (int i = 0; i < CODE_LEN; i++) send_beat(mags[i], $urandom_range(0, max_bubble));
   endtask

   task automatic check_result(input string tag);
      int m1, i1, m2, i2;
      ref_result(m1, i1, m2, i2);
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 1);
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      check_eq({tag, "_busy"}, 32'(bus.busy), 1);
      check_eq({tag, "_min1_mag"}, 32'(bus.out_min1_mag), m1);
      check_eq({tag, "_min1_idx"}, 32'(bus.out_min1_idx), i1);
      check_eq({tag, "_min2_mag"}, 32'(bus.out_min2_mag), m2);
      check_eq({tag, "_min2_idx"}, 32'(bus.out_min2_idx), i2);
   endtask

   task automatic hold_release(input string tag, input int hold_cycles);
      bus.out_ready = 1'b0;
      for (int h = 0; h < hold_cycles; h++) begin
         bus.in_valid = 1'b1;
         bus.in_mag   = '0;
         @(negedge clk);
         bus.in_valid = 1'b0;
         check_result({tag, "_hold"});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      acc_q.delete();
      check_empty({tag, "_after_hs"});
   endtask

   task automatic do_clear(input string tag);
      bus.in_clear = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_mag   = '0;
      check_eq({tag, "_in_ready_at_clear"}, 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_clear = 1'b0;
      bus.in_valid = 1'b0;
      acc_q.delete();
      check_empty({tag, "_after_clear"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.in_clear  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mag    = '0;
      bus.out_ready = 1'b0;
      rstn = 1'b0;
      #12;
      check_empty("reset");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      send_frame(f_case1, 0);
      check_result("case1");
      check_eq("case1_min1_mag_const", 32'(bus.out_min1_mag), 1);
      check_eq("case1_min1_idx_const", 32'(bus.out_min1_idx), 3);
      check_eq("case1_min2_mag_const", 32'(bus.out_min2_mag), 2);
      check_eq("case1_min2_idx_const", 32'(bus.out_min2_idx), 5);
      hold_release("case1", 1);

      send_frame(f_all7, 0);
      check_result("all7");
      check_eq("all7_min1_idx_const", 32'(bus.out_min1_idx), 0);
      check_eq("all7_min2_idx_const", 32'(bus.out_min2_idx), 1);
      check_eq("all7_min2_mag_const", 32'(bus.out_min2_mag), 7);
      hold_release("all7", 0);

      // Bubble between every beat, long hold; the next frame then must start at idx 0.
      for (int i = 0; i < CODE_LEN; i++) send_beat(f_case1[i], 1 + i % 2);
      check_result("bubbles");
      hold_release("bubbles", 10);
      send_frame(f_case1, 0);
      check_eq("restart_min1_idx_const", 32'(bus.out_min1_idx), 3);
      hold_release("restart", 2);

      for (int i = 0; i < 4; i++) send_beat(0, 0);
      do_clear("abort");
      send_frame(f_case4, 0);
      check_result("case4");
      check_eq("case4_min1_idx_const", 32'(bus.out_min1_idx), 7);
      check_eq("case4_min2_idx_const", 32'(bus.out_min2_idx), 2);
      check_eq("case4_min2_mag_const", 32'(bus.out_min2_mag), 3);
      hold_release("case4", 1);

      for (int i = 0; i < 5; i++) send_beat(f_case1[i], 0);
      check_eq("midframe_busy", 32'(bus.busy), 1);
      #2;
      rstn = 1'b0;
      #1;
      check_empty("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      acc_q.delete();
      @(negedge clk);
      send_frame(f_case1, 0);
      check_result("post_rst");
      check_eq("post_rst_min2_idx_const", 32'(bus.out_min2_idx), 5);
      hold_release("post_rst", 0);

      send_frame(f_case1, 1);
      check_result("clr_hs");
      bus.in_clear  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_clear  = 1'b0;
      bus.out_ready = 1'b0;
      acc_q.delete();
      check_empty("clr_hs");

      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < CODE_LEN; i++) f_rand[i] = $urandom_range(0, MAG_ONES);
         if ($urandom_range(0, 3) == 0) begin
            abort_at = $urandom_range(1, CODE_LEN - 1);
            for (int i = 0; i < abort_at; i++) send_beat(f_rand[i], $urandom_range(0, 2));
            do_clear("rand_abort");
         end
         send_frame(f_rand, 2);
         check_result("rand");
         hold_release("rand", $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
